// File: rtl/key_debounce_edge.sv
// Multi-key debouncer: per-key two-flop synchroniser, stable-sample counter,
// one-cycle press/release pulses and optional hold-to-repeat press pulses.

module key_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_RATE     = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic press_nxt
);
    localparam logic IDLE = (ACTIVE_LOW != 0);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        R_OFF,
        R_DELAY,
        R_RATE
    } rpt_t;

    logic          s1;
    logic          s2;
    logic          p;
    logic          accept;
    logic          fire;
    logic          rel_nxt;
    logic [CW-1:0] cnt;

    // Idle value on reset keeps a released key from looking like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= IDLE;
            s2 <= IDLE;
        end else begin
            s1 <= key;
            s2 <= s1;
        end
    end

    assign p      = s2 ^ IDLE;
    assign accept = (p != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (p == level) begin
            cnt <= '0;
        end else if (accept) begin
            cnt   <= '0;
            level <= p;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (REPEAT_DELAY > 0) begin : g_rpt
            localparam int RMAX =
                (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int RW = $clog2(RMAX + 1);
            localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

            rpt_t          state;
            rpt_t          state_n;
            logic [RW-1:0] rc;
            logic [RW-1:0] rc_n;
            logic          fire_c;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state <= R_OFF;
                    rc    <= '0;
                end else begin
                    state <= state_n;
                    rc    <= rc_n;
                end
            end

            // Any accept while held is a release, which must beat a repeat.
            always_comb begin
                state_n = state;
                rc_n    = rc;
                fire_c  = 1'b0;
                unique case (state)
                    R_OFF: begin
                        rc_n = '0;
                        if (accept && p) begin
                            state_n = R_DELAY;
                        end
                    end
                    R_DELAY: begin
                        if (accept) begin
                            state_n = R_OFF;
                            rc_n    = '0;
                        end else if (rc == DELAY_LAST) begin
                            fire_c  = 1'b1;
                            rc_n    = '0;
                            state_n = R_RATE;
                        end else begin
                            rc_n = rc + 1'b1;
                        end
                    end
                    R_RATE: begin
                        if (accept) begin
                            state_n = R_OFF;
                            rc_n    = '0;
                        end else if (rc == RATE_LAST) begin
                            fire_c = 1'b1;
                            rc_n   = '0;
                        end else begin
                            rc_n = rc + 1'b1;
                        end
                    end
                    default: begin
                        state_n = R_OFF;
                        rc_n    = '0;
                    end
                endcase
            end

            assign fire = fire_c;
        end else begin : g_no_rpt
            assign fire = 1'b0;
        end
    endgenerate

    assign press_nxt = (accept & p) | fire;
    assign rel_nxt   = accept & ~p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= press_nxt;
            release_pulse <= rel_nxt;
        end
    end
endmodule

module key_debounce_edge #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_RATE     = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_pulse,
    output logic              any_press
);
    logic [N_KEYS-1:0] press_nxt;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .key          (key[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .press_nxt    (press_nxt[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_nxt;
        end
    end
endmodule

// File: tb/tb_key_debounce_edge.sv
// Scoreboard bench for key_debounce_edge: two instances, one plain
// debounce (4 samples) and one with auto-repeat (2 samples, 10/5 repeat).

module tb_key_debounce_edge;
    localparam int NK = 4;

    typedef struct {
        int            cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } exp_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key_a = '1;
    logic [NK-1:0] key_b = '1;
    logic [NK-1:0] level_a, press_a, rel_a;
    logic [NK-1:0] level_b, press_b, rel_b;
    logic          any_a, any_b;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    key_debounce_edge #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
        .REPEAT_DELAY(0), .REPEAT_RATE(1)
    ) dut_a (
        .clk(clk), .reset(reset), .key(key_a), .level(level_a),
        .press(press_a), .release_pulse(rel_a), .any_press(any_a)
    );

    key_debounce_edge #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(2), .ACTIVE_LOW(1),
        .REPEAT_DELAY(10), .REPEAT_RATE(5)
    ) dut_b (
        .clk(clk), .reset(reset), .key(key_b), .level(level_b),
        .press(press_b), .release_pulse(rel_b), .any_press(any_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input int c, input logic [NK-1:0] p,
                         input logic [NK-1:0] r);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r;
        qa.push_back(e);
    endtask

    task automatic exp_b(input int c, input logic [NK-1:0] p,
                         input logic [NK-1:0] r);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r;
        qb.push_back(e);
    endtask

    task automatic cmp(input string name, input exp_t e,
                       input logic [NK-1:0] p, input logic [NK-1:0] r,
                       input logic any);
        checks++;
        if (e.cyc != cyc || p !== e.press || r !== e.rel
            || any !== (e.press != '0)) begin
            errors++;
            $display("FAIL %s: got cyc=%0d press=%b release=%b any=%b, expected cyc=%0d press=%b release=%b any=%b",
                     name, cyc, p, r, any, e.cyc, e.press, e.rel,
                     (e.press != '0));
        end
    endtask

    task automatic unexpected(input string name, input logic [NK-1:0] p,
                              input logic [NK-1:0] r, input logic any);
        checks++;
        errors++;
        $display("FAIL %s: got cyc=%0d press=%b release=%b any=%b, expected no pulse",
                 name, cyc, p, r, any);
    endtask

    // Monitor: every pulse the DUT presents must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ((press_a | rel_a) != '0 || any_a) begin
                    if (qa.size() == 0) unexpected("a_pulse", press_a, rel_a, any_a);
                    else cmp("a_pulse", qa.pop_front(), press_a, rel_a, any_a);
                end
                if ((press_b | rel_b) != '0 || any_b) begin
                    if (qb.size() == 0) unexpected("b_pulse", press_b, rel_b, any_b);
                    else cmp("b_pulse", qb.pop_front(), press_b, rel_b, any_b);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int t;
        int r;
        repeat (3) @(negedge clk);
        chk("rst_level_a", level_a, 0);
        chk("rst_press_a", press_a, 0);
        chk("rst_rel_a", rel_a, 0);
        chk("rst_any_a", any_a, 0);
        chk("rst_level_b", level_b, 0);
        step(1);
        reset = 1'b0;
        step(100);
        chk("idle_level_a", level_a, 0);
        chk("idle_level_b", level_b, 0);

        // single press: pulse 2+4 edges after the change
        e0 = cyc;
        key_a[0] = 1'b0;
        exp_a(e0 + 6, 4'b0001, 4'b0000);
        step(12);
        chk("press_level", level_a, 4'b0001);

        // 3-sample glitches never reach the 4-sample threshold
        for (int i = 0; i < 10; i++) begin
            key_a[1] = 1'b0;
            step(3);
            key_a[1] = 1'b1;
            step(3);
        end
        step(8);
        chk("glitch_level", level_a, 4'b0001);

        e0 = cyc;
        key_a[0] = 1'b1;
        exp_a(e0 + 6, 4'b0000, 4'b0001);
        step(10);
        chk("release_level", level_a, 4'b0000);

        e0 = cyc;
        key_a[0] = 1'b0;
        exp_a(e0 + 6, 4'b0001, 4'b0000);
        step(10);
        chk("repress_level", level_a, 4'b0001);

        // bouncy release settles at e0+8
        e0 = cyc;
        exp_a(e0 + 14, 4'b0000, 4'b0001);
        key_a[0] = 1'b1; step(2);
        key_a[0] = 1'b0; step(2);
        key_a[0] = 1'b1; step(2);
        key_a[0] = 1'b0; step(2);
        key_a[0] = 1'b1;
        step(12);
        chk("bounce_level", level_a, 4'b0000);

        // auto-repeat; release lands on T+40 where a repeat would fire
        e0 = cyc;
        t = e0 + 4;
        key_b[2] = 1'b0;
        exp_b(t, 4'b0100, 4'b0000);
        for (int k = 10; k <= 35; k += 5) exp_b(t + k, 4'b0100, 4'b0000);
        exp_b(t + 40, 4'b0000, 4'b0100);
        step(20);
        chk("rpt_level_held", level_b, 4'b0100);
        step(20);
        key_b[2] = 1'b1;
        step(20);
        chk("rpt_level_rel", level_b, 4'b0000);

        // two keys on one edge
        e0 = cyc;
        key_a = 4'b0110;
        exp_a(e0 + 6, 4'b1001, 4'b0000);
        step(10);
        chk("dual_level", level_a, 4'b1001);

        // reset two counts into a key[1] press
        key_a[1] = 1'b0;
        step(4);
        reset = 1'b1;
        #1;
        chk("mid_rst_level", level_a, 0);
        chk("mid_rst_press", press_a, 0);
        chk("mid_rst_rel", rel_a, 0);
        chk("mid_rst_any", any_a, 0);
        step(3);
        reset = 1'b0;
        r = cyc;
        exp_a(r + 6, 4'b1011, 4'b0000);
        step(10);
        chk("post_rst_level", level_a, 4'b1011);

        e0 = cyc;
        key_a = 4'b1111;
        exp_a(e0 + 6, 4'b0000, 4'b1011);
        step(10);
        chk("final_level", level_a, 4'b0000);

        step(5);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
